// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and lane-steering helpers for the data-memory controller.
package mem_pkg;

  // Access size codes as presented on mem_read / mem_write.
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Half accesses need an even address, word accesses a multiple of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic res;
    case (size)
      MEM_HALF: res = lane[0];
      MEM_WORD: res = (lane != 2'b00);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  // Little-endian byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << lane;
      MEM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across every lane; byte enables pick the live one.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] res;
    case (size)
      MEM_BYTE: res = {4{data[7:0]}};
      MEM_HALF: res = {2{data[15:0]}};
      default:  res = data;
    endcase
    return res;
  endfunction

  // Pick the addressed lane out of a RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: res = {{24{~uns & b[7]}}, b};
      MEM_HALF: res = {{16{~uns & h[15]}}, h};
      MEM_WORD: res = word;
      default:  res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables. Contents have no reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] index,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // Byte-masked write or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts MA-stage loads/stores, stalls the pipeline for the
// programmed latency, and returns lane-extracted, extended load data in the response cycle.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  mem_read,
  input  logic        load_unsigned,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign_err
);

  // The accept cycle counts as the first busy cycle, so WAIT lasts LATENCY-1 cycles.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit SINGLE = (LATENCY == 1);

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                wr_r;
  logic [1:0]          size_r;
  logic [ADDR_W+1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic                uns_r;

  logic                is_write_s;
  logic [1:0]          req_size_s;
  logic                req_s;
  logic                mis_s;
  logic                accept_s;
  logic                access_s;
  logic                acc_write_s;
  logic [1:0]          acc_size_s;
  logic [ADDR_W+1:0]   acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic                ram_we_s;
  logic                ram_re_s;
  logic [3:0]          ram_be_s;
  logic [31:0]         ram_wdata_s;
  logic [31:0]         ram_q_s;
  logic                unused_addr_s;

  // Address bits above the RAM size alias; they are deliberately ignored.
  assign unused_addr_s = ^addr[31:ADDR_W+2];

  // Request decode: a write wins over a simultaneous read; nothing is honoured in reset.
  always_comb begin
    is_write_s = (mem_write != MEM_NONE);
    req_size_s = is_write_s ? mem_write : mem_read;
    req_s      = reset && (is_write_s || (mem_read != MEM_NONE));
    mis_s      = req_s && misaligned(req_size_s, addr[1:0]);
    accept_s   = (state_r == IDLE) && req_s && !mis_s;
  end

  // RAM operands come straight from the pipeline on a single-cycle accept, else from the capture.
  always_comb begin
    if (state_r == IDLE) begin
      acc_write_s = is_write_s;
      acc_size_s  = req_size_s;
      acc_addr_s  = addr[ADDR_W+1:0];
      acc_wdata_s = wdata;
      access_s    = accept_s && SINGLE;
    end else begin
      acc_write_s = wr_r;
      acc_size_s  = size_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      access_s    = (state_r == WAIT) && (cnt_r <= 4'd1);
    end
    ram_we_s    = access_s && acc_write_s;
    ram_re_s    = access_s && !acc_write_s;
    ram_be_s    = store_be(acc_size_s, acc_addr_s[1:0]);
    ram_wdata_s = store_lanes(acc_size_s, acc_wdata_s);
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .index (acc_addr_s[ADDR_W+1:2]),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .rdata (ram_q_s)
  );

  // Pipeline-facing outputs: stall, misalignment pulse, and extended load data in RESP only.
  always_comb begin
    busy         = accept_s || (state_r == WAIT);
    misalign_err = (state_r == IDLE) && mis_s;
    if ((state_r == RESP) && !wr_r) begin
      rdata = load_extend(ram_q_s, size_r, addr_r[1:0], uns_r);
    end else begin
      rdata = 32'd0;
    end
  end

  // Access sequencer: capture on accept, count down the latency, then one response cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      size_r  <= MEM_NONE;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      uns_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wr_r    <= is_write_s;
            size_r  <= req_size_s;
            addr_r  <= addr[ADDR_W+1:0];
            wdata_r <= wdata;
            uns_r   <= load_unsigned;
            cnt_r   <= LAT_M1;
            state_r <= SINGLE ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= RESP;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
